sram_1rw_ctrl: RTL and testbench

Request-side controller placed directly upstream of a single-port (1RW) OpenRAM macro such as `sram_2_16_1_freepdk45`. It converts a valid/ready request stream into the macro's active-low `csb0`/`web0` protocol with registered outputs. It captures read data from `dout0` into a small response FIFO with credit-based backpressure. After reset it can zero-fill the whole array before accepting traffic.

---
 rtl/sram_ctrl_pkg.sv | 16 +
 rtl/sram_rsp_fifo.sv | 86 ++++++++
 rtl/sram_1rw_ctrl.sv | 195 +++++++++++++++++++
 tb/tb_sram_1rw_ctrl.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg
// Shared definitions for the single-port SRAM request controller:
//   - ctrl_state_e   : controller FSM states (array zero-fill, normal run)
//   - DEF_*          : default widths used by the sram_1rw_ctrl wrapper
package sram_ctrl_pkg;

    localparam int unsigned DEF_DATA_WIDTH = 32'd2;
    localparam int unsigned DEF_ADDR_WIDTH = 32'd4;
    localparam int unsigned DEF_RSP_DEPTH  = 32'd2;

    typedef enum logic [0:0] {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } ctrl_state_e;

endpackage

// File: rtl/sram_rsp_fifo.sv
// sram_rsp_fifo
// Small synchronous FIFO holding read data returned by the macro.
// Ports:
//   clk0, rst0_n : clock, asynchronous active-low reset
//   push, wdata  : write one word (ignored when full and not popping)
//   pop          : remove the head word (ignored when empty)
//   rdata        : head word, stable until popped
//   count        : current occupancy
//   valid        : registered "not empty" flag
module sram_rsp_fifo #(
    parameter int unsigned DATA_WIDTH = 32'd2,
    parameter int unsigned RSP_DEPTH  = 32'd2
) (
    input  logic                             clk0,
    input  logic                             rst0_n,
    input  logic                             push,
    input  logic                             pop,
    input  logic [DATA_WIDTH-1:0]            wdata,
    output logic [DATA_WIDTH-1:0]            rdata,
    output logic [$clog2(RSP_DEPTH+1)-1:0]   count,
    output logic                             valid
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam int unsigned PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR_C = PTR_W'(RSP_DEPTH - 1);
    localparam logic [CNT_W-1:0] FULL_C     = CNT_W'(RSP_DEPTH);

    logic [DATA_WIDTH-1:0] mem_r [RSP_DEPTH];
    logic [PTR_W-1:0]      wr_ptr_r;
    logic [PTR_W-1:0]      rd_ptr_r;
    logic [CNT_W-1:0]      count_r;
    logic [CNT_W-1:0]      count_nxt_s;
    logic                  valid_r;
    logic                  push_ok_s;
    logic                  pop_ok_s;

    // Pointer advance with wrap, so the depth need not be a power of two.
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        if (p == LAST_PTR_C) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    assign pop_ok_s  = pop && (count_r != {CNT_W{1'b0}});
    assign push_ok_s = push && ((count_r != FULL_C) || pop_ok_s);
    assign rdata     = mem_r[rd_ptr_r];
    assign count     = count_r;
    assign valid     = valid_r;

    // Occupancy after this edge; simultaneous push and pop leave it unchanged.
    always_comb begin
        count_nxt_s = count_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   count_nxt_s = count_r + CNT_W'(1);
            2'b01:   count_nxt_s = count_r - CNT_W'(1);
            default: count_nxt_s = count_r;
        endcase
    end

    // Storage, pointers, occupancy and the registered not-empty flag.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            for (int i = 0; i < int'(RSP_DEPTH); i++) begin
                mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
            valid_r  <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r] <= wdata;
                wr_ptr_r        <= ptr_inc(wr_ptr_r);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= ptr_inc(rd_ptr_r);
            end
            count_r <= count_nxt_s;
            valid_r <= (count_nxt_s != {CNT_W{1'b0}});
        end
    end

endmodule

// File: rtl/sram_1rw_ctrl.sv
// sram_1rw_ctrl
// Request-side controller in front of a 1RW OpenRAM macro. Converts a
// valid/ready request stream into registered active-low csb0/web0 macro
// cycles, returns read data in order through a credit-limited response FIFO,
// and optionally zero-fills the whole array after reset.
// Ports:
//   clk0, rst0_n                         : clock, asynchronous active-low reset
//   req_valid/req_ready/req_we/req_addr/req_wdata : request stream
//   rsp_valid/rsp_ready/rsp_rdata        : read response stream
//   init_done                            : high once normal operation starts
//   csb0/web0/addr0/din0/dout0           : macro port 0
module sram_1rw_ctrl
    import sram_ctrl_pkg::*;
#(
    parameter int unsigned DATA_WIDTH    = DEF_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH    = DEF_ADDR_WIDTH,
    parameter int unsigned RSP_DEPTH     = DEF_RSP_DEPTH,
    parameter bit          INIT_ON_RESET = 1'b1
) (
    input  logic                  clk0,
    input  logic                  rst0_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  init_done,
    output logic                  csb0,
    output logic                  web0,
    output logic [ADDR_WIDTH-1:0] addr0,
    output logic [DATA_WIDTH-1:0] din0,
    input  logic [DATA_WIDTH-1:0] dout0
);

    localparam int unsigned CNT_W = $clog2(RSP_DEPTH + 1);
    localparam logic [CNT_W:0]        CREDIT_LIM_C = (CNT_W + 1)'(RSP_DEPTH);
    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR_C  = {ADDR_WIDTH{1'b1}};
    localparam ctrl_state_e           RST_STATE_C  = INIT_ON_RESET ? ST_INIT : ST_RUN;

    ctrl_state_e           state_r;
    ctrl_state_e           state_nxt_s;
    logic [ADDR_WIDTH-1:0] init_cnt_r;
    logic [ADDR_WIDTH-1:0] init_cnt_nxt_s;
    logic                  csb0_nxt_s;
    logic                  web0_nxt_s;
    logic [ADDR_WIDTH-1:0] addr0_nxt_s;
    logic [DATA_WIDTH-1:0] din0_nxt_s;
    logic                  accept_s;
    logic                  acc_rd_s;
    logic                  rd_p1_r;
    logic                  rd_p2_r;
    logic                  push_s;
    logic                  pop_s;
    logic [CNT_W-1:0]      inflight_r;
    logic [CNT_W-1:0]      inflight_nxt_s;
    logic [CNT_W-1:0]      fifo_cnt_s;
    logic [CNT_W-1:0]      fifo_cnt_nxt_s;
    logic                  ready_nxt_s;

    // req_ready is only ever high in RUN, so this is the full accept condition.
    assign accept_s = req_valid && req_ready;
    assign acc_rd_s = accept_s && !req_we;
    // A read issued at edge E is captured from dout0 at edge E+2.
    assign push_s   = rd_p2_r;
    assign pop_s    = rsp_valid && rsp_ready;

    // FSM state register.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            state_r <= RST_STATE_C;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state: leave INIT on the edge that issues the last address.
    always_comb begin
        state_nxt_s = state_r;
        case (state_r)
            ST_INIT: begin
                if (init_cnt_r == LAST_ADDR_C) begin
                    state_nxt_s = ST_RUN;
                end else begin
                    state_nxt_s = ST_INIT;
                end
            end
            ST_RUN:  state_nxt_s = ST_RUN;
            default: state_nxt_s = RST_STATE_C;
        endcase
    end

    // FSM outputs: next values of the macro issue flops and the init counter.
    always_comb begin
        csb0_nxt_s     = 1'b1;
        web0_nxt_s     = 1'b1;
        addr0_nxt_s    = addr0;
        din0_nxt_s     = din0;
        init_cnt_nxt_s = init_cnt_r;
        case (state_r)
            ST_INIT: begin
                csb0_nxt_s     = 1'b0;
                web0_nxt_s     = 1'b0;
                addr0_nxt_s    = init_cnt_r;
                din0_nxt_s     = {DATA_WIDTH{1'b0}};
                init_cnt_nxt_s = init_cnt_r + ADDR_WIDTH'(1);
            end
            ST_RUN: begin
                if (accept_s) begin
                    csb0_nxt_s  = 1'b0;
                    web0_nxt_s  = !req_we;
                    addr0_nxt_s = req_addr;
                    if (req_we) begin
                        din0_nxt_s = req_wdata;
                    end else begin
                        din0_nxt_s = din0;
                    end
                end else begin
                    csb0_nxt_s = 1'b1;
                    web0_nxt_s = 1'b1;
                end
            end
            default: begin
                csb0_nxt_s = 1'b1;
                web0_nxt_s = 1'b1;
            end
        endcase
    end

    // Credit bookkeeping: every outstanding read (in the macro pipeline or
    // waiting in the FIFO) holds one credit; writes never take one.
    always_comb begin
        inflight_nxt_s = inflight_r;
        fifo_cnt_nxt_s = fifo_cnt_s;
        case ({acc_rd_s, push_s})
            2'b10:   inflight_nxt_s = inflight_r + CNT_W'(1);
            2'b01:   inflight_nxt_s = inflight_r - CNT_W'(1);
            default: inflight_nxt_s = inflight_r;
        endcase
        case ({push_s, pop_s})
            2'b10:   fifo_cnt_nxt_s = fifo_cnt_s + CNT_W'(1);
            2'b01:   fifo_cnt_nxt_s = fifo_cnt_s - CNT_W'(1);
            default: fifo_cnt_nxt_s = fifo_cnt_s;
        endcase
        if (state_nxt_s == ST_RUN) begin
            ready_nxt_s = ({1'b0, inflight_nxt_s} + {1'b0, fifo_cnt_nxt_s}) < CREDIT_LIM_C;
        end else begin
            ready_nxt_s = 1'b0;
        end
    end

    // Issue flops, read-return pipeline, credits and status outputs.
    always_ff @(posedge clk0 or negedge rst0_n) begin
        if (!rst0_n) begin
            csb0       <= 1'b1;
            web0       <= 1'b1;
            addr0      <= {ADDR_WIDTH{1'b0}};
            din0       <= {DATA_WIDTH{1'b0}};
            init_cnt_r <= {ADDR_WIDTH{1'b0}};
            rd_p1_r    <= 1'b0;
            rd_p2_r    <= 1'b0;
            inflight_r <= {CNT_W{1'b0}};
            req_ready  <= 1'b0;
            init_done  <= 1'b0;
        end else begin
            csb0       <= csb0_nxt_s;
            web0       <= web0_nxt_s;
            addr0      <= addr0_nxt_s;
            din0       <= din0_nxt_s;
            init_cnt_r <= init_cnt_nxt_s;
            rd_p1_r    <= acc_rd_s;
            rd_p2_r    <= rd_p1_r;
            inflight_r <= inflight_nxt_s;
            req_ready  <= ready_nxt_s;
            init_done  <= (state_nxt_s == ST_RUN);
        end
    end

    sram_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH)
    ) u_rsp_fifo (
        .clk0   (clk0),
        .rst0_n (rst0_n),
        .push   (push_s),
        .pop    (pop_s),
        .wdata  (dout0),
        .rdata  (rsp_rdata),
        .count  (fifo_cnt_s),
        .valid  (rsp_valid)
    );

endmodule

// File: tb/tb_sram_1rw_ctrl.sv
// tb_sram_1rw_ctrl
// Bench for sram_1rw_ctrl. Instance dut uses the defaults (zero-fill on
// reset); instance dut_b skips zero-fill. Each has a behavioural 1RW macro
// (sample on rising edge, act on falling edge). The reference model for dut
// tracks an array image, a queue of pending read results with their due
// cycle, and the outstanding-read count that bounds acceptance.
module tb_sram_1rw_ctrl;

    localparam int DEPTH = 16;
    localparam int RSPD  = 2;

    logic       clk0;
    logic       rst0_n, req_valid, req_ready, req_we, rsp_valid, rsp_ready, init_done, csb0, web0;
    logic [3:0] req_addr, addr0;
    logic [1:0] req_wdata, rsp_rdata, din0, dout0;

    logic       rst_b_n, req_valid_b, req_ready_b, req_we_b, rsp_valid_b, rsp_ready_b, init_done_b, csb0_b, web0_b;
    logic [3:0] req_addr_b, addr0_b;
    logic [1:0] req_wdata_b, rsp_rdata_b, din0_b, dout0_b;

    int n_vec = 0;
    int n_err = 0;

    sram_1rw_ctrl dut (
        .clk0(clk0), .rst0_n(rst0_n), .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .init_done(init_done), .csb0(csb0), .web0(web0), .addr0(addr0),
        .din0(din0), .dout0(dout0)
    );

    sram_1rw_ctrl #(.INIT_ON_RESET(1'b0)) dut_b (
        .clk0(clk0), .rst0_n(rst_b_n), .req_valid(req_valid_b), .req_ready(req_ready_b),
        .req_we(req_we_b), .req_addr(req_addr_b), .req_wdata(req_wdata_b),
        .rsp_valid(rsp_valid_b), .rsp_ready(rsp_ready_b), .rsp_rdata(rsp_rdata_b),
        .init_done(init_done_b), .csb0(csb0_b), .web0(web0_b), .addr0(addr0_b),
        .din0(din0_b), .dout0(dout0_b)
    );

    initial clk0 = 1'b0;
    always #5 clk0 = ~clk0;

    // ---------------- behavioural macros ----------------
    logic [1:0] mem_a [DEPTH];
    logic [1:0] mem_b [DEPTH];
    logic       seeded = 1'b0;
    logic       m_cs_a, m_we_a, m_cs_b, m_we_b;
    logic [3:0] m_addr_a, m_addr_b;
    logic [1:0] m_din_a, m_din_b;

    always @(posedge clk0) begin
        m_cs_a <= !csb0;   m_we_a <= !web0;   m_addr_a <= addr0;   m_din_a <= din0;
        m_cs_b <= !csb0_b; m_we_b <= !web0_b; m_addr_b <= addr0_b; m_din_b <= din0_b;
    end

    always @(negedge clk0) begin
        if (!seeded) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_a[i] <= 2'($urandom_range(1, 3));
                mem_b[i] <= 2'($urandom_range(0, 3));
            end
            seeded <= 1'b1;
        end else begin
            if (m_cs_a) begin
                if (m_we_a) mem_a[m_addr_a] <= m_din_a;
                else        dout0 <= mem_a[m_addr_a];
            end
            if (m_cs_b) begin
                if (m_we_b) mem_b[m_addr_b] <= m_din_b;
                else        dout0_b <= mem_b[m_addr_b];
            end
        end
    end

    // ---------------- reference model for dut ----------------
    typedef struct { int due; logic [1:0] data; } rsp_t;
    rsp_t       q[$];
    logic [1:0] ref_mem [DEPTH];
    int         edges, cyc;
    logic       exp_ready, exp_valid, last_acc;
    logic       e_csb, e_web;
    logic [3:0] e_addr;
    logic [1:0] e_din;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_clear();
        q.delete();
        edges = 0;
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = 2'b00;
        e_csb = 1'b1; e_web = 1'b1; e_addr = 4'd0; e_din = 2'd0;
        exp_ready = 1'b0; exp_valid = 1'b0; last_acc = 1'b0;
    endtask

    task automatic check_a();
        exp_valid = (q.size() > 0) && (q[0].due <= cyc);
        exp_ready = (edges >= DEPTH) && (q.size() < RSPD);
        chk("req_ready", 32'(req_ready), 32'(exp_ready));
        chk("rsp_valid", 32'(rsp_valid), 32'(exp_valid));
        if (exp_valid) chk("rsp_rdata", 32'(rsp_rdata), 32'(q[0].data));
        chk("init_done", 32'(init_done), 32'(edges >= DEPTH));
        chk("csb0", 32'(csb0), 32'(e_csb));
        chk("web0", 32'(web0), 32'(e_web));
        chk("addr0", 32'(addr0), 32'(e_addr));
        chk("din0", 32'(din0), 32'(e_din));
    endtask

    task automatic model_a();
        cyc++;
        if (edges < DEPTH) begin
            e_csb = 1'b0; e_web = 1'b0; e_addr = 4'(edges); e_din = 2'd0; last_acc = 1'b0;
        end else begin
            last_acc = req_valid && exp_ready;
            if (last_acc) begin
                e_csb = 1'b0; e_web = !req_we; e_addr = req_addr;
                if (req_we) begin
                    e_din = req_wdata;
                    ref_mem[req_addr] = req_wdata;
                end
            end else begin
                e_csb = 1'b1; e_web = 1'b1;
            end
        end
        if (exp_valid && rsp_ready) void'(q.pop_front());
        if (last_acc && !req_we) q.push_back('{due: cyc + 2, data: ref_mem[req_addr]});
        edges++;
    endtask

    task automatic step(input logic v, input logic we, input logic [3:0] a,
                        input logic [1:0] d, input logic rr);
        @(negedge clk0);
        check_a();
        req_valid = v; req_we = we; req_addr = a; req_wdata = d; rsp_ready = rr;
        @(posedge clk0);
        model_a();
    endtask

    task automatic send(input logic we, input logic [3:0] a, input logic [1:0] d, input logic rr);
        logic done = 1'b0;
        for (int t = 0; t < 20 && !done; t++) begin
            step(1'b1, we, a, d, rr);
            done = last_acc;
        end
        chk("accept_bound", 32'(done), 32'd1);
    endtask

    task automatic idle(input int n, input logic rr);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 4'd0, 2'd0, rr);
    endtask

    task automatic reset_a();
        @(negedge clk0);
        check_a();
        rst0_n = 1'b0; req_valid = 1'b0; rsp_ready = 1'b0;
        #1;
        chk("rst_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("rst_csb0", 32'(csb0), 32'd1);
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_init_done", 32'(init_done), 32'd0);
        model_clear();
        repeat (2) @(posedge clk0);
        @(negedge clk0);
        check_a();
        rst0_n = 1'b1;
        @(posedge clk0);
        model_a();
    endtask

    initial begin
        logic seen;
        rst0_n = 1'b0; req_valid = 1'b0; req_we = 1'b0; req_addr = 4'd0; req_wdata = 2'd0; rsp_ready = 1'b0;
        rst_b_n = 1'b0; req_valid_b = 1'b0; req_we_b = 1'b0; req_addr_b = 4'd0; req_wdata_b = 2'd0; rsp_ready_b = 1'b0;
        cyc = 0;
        model_clear();
        repeat (3) @(posedge clk0);
        @(negedge clk0);
        check_a();
        rst0_n = 1'b1;
        @(posedge clk0);
        model_a();

        // zero-fill: 16 write cycles, then a read of address 7
        idle(DEPTH + 2, 1'b1);
        send(1'b0, 4'd7, 2'd0, 1'b1);
        idle(4, 1'b1);

        // read-after-write on consecutive cycles
        send(1'b1, 4'd3, 2'b10, 1'b1);
        send(1'b0, 4'd3, 2'd0, 1'b1);
        idle(4, 1'b1);

        // preload 1,2,3,0 then four reads with the consumer always ready
        for (int i = 0; i < 4; i++) send(1'b1, 4'(i), 2'(i + 1), 1'b1);
        for (int i = 0; i < 4; i++) send(1'b0, 4'(i), 2'd0, 1'b1);
        idle(5, 1'b1);

        // consumer stalled: credits run out, then drain in order
        for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 4'(3 - (i % 4)), 2'd0, 1'b0);
        idle(6, 1'b1);

        // randomized traffic
        for (int i = 0; i < 400; i++) begin
            step($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                 2'($urandom_range(0, 3)), $urandom_range(0, 3) != 0);
        end
        idle(6, 1'b1);

        // reset with two reads in flight, then re-init and more traffic
        send(1'b0, 4'd1, 2'd0, 1'b0);
        send(1'b0, 4'd2, 2'd0, 1'b0);
        reset_a();
        idle(DEPTH + 2, 1'b1);
        send(1'b0, 4'd1, 2'd0, 1'b1);
        idle(4, 1'b1);

        // instance without zero-fill
        @(negedge clk0);
        chk("b_rst_init_done", 32'(init_done_b), 32'd0);
        chk("b_rst_req_ready", 32'(req_ready_b), 32'd0);
        rst_b_n = 1'b1;
        req_valid_b = 1'b1; req_we_b = 1'b1; req_addr_b = 4'd5; req_wdata_b = 2'd3;
        @(negedge clk0);
        chk("b_init_done", 32'(init_done_b), 32'd1);
        chk("b_req_ready", 32'(req_ready_b), 32'd1);
        chk("b_idle_csb0", 32'(csb0_b), 32'd1);
        @(negedge clk0);
        chk("b_wr_csb0", 32'(csb0_b), 32'd0);
        chk("b_wr_web0", 32'(web0_b), 32'd0);
        chk("b_wr_addr0", 32'(addr0_b), 32'd5);
        chk("b_wr_din0", 32'(din0_b), 32'd3);
        req_we_b = 1'b0;
        @(negedge clk0);
        chk("b_rd_csb0", 32'(csb0_b), 32'd0);
        chk("b_rd_web0", 32'(web0_b), 32'd1);
        req_valid_b = 1'b0; rsp_ready_b = 1'b1;
        seen = 1'b0;
        for (int t = 0; t < 6 && !seen; t++) begin
            @(negedge clk0);
            seen = rsp_valid_b;
        end
        chk("b_rsp_valid", 32'(seen), 32'd1);
        chk("b_rsp_rdata", 32'(rsp_rdata_b), 32'd3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
